// File: rtl/rom_arbiter_pkg.sv
// Shared types and default widths for the ROM arbiter: port identifiers and the alignment helper.
package rom_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 32;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LD = 1'b1
    } arb_port_e;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Request/response bundle for one ROM requester; master is the requester, slave is the arbiter.
interface rom_arbiter_if
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;

    modport master (
        output req, addr,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/rom_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, on conflict the requester not granted last wins.
module rr_arb2 #(
    parameter logic LAST_RESET = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt
);

    logic r_lastGnt;

    // Remember who won most recently so the other side gets the next conflict.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lastGnt <= LAST_RESET;
        end else if (i_advance) begin
            r_lastGnt <= o_gnt[1];
        end
    end

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_lastGnt ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares a single-port synchronous ROM between instruction fetch (IF) and load (LD) ports.
// Optional performance counters are built when ROM_ARB_PERF_EN is defined.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
`ifdef ROM_ARB_PERF_EN
    ,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    rom_arbiter_if.slave          ifBus,
    rom_arbiter_if.slave          ldBus,
    output logic                  rom_ce_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_rdata_i
`ifdef ROM_ARB_PERF_EN
    ,
    input  logic                  perf_clr_i,
    output logic [CNT_WIDTH-1:0]  if_gnt_cnt_o,
    output logic [CNT_WIDTH-1:0]  ld_gnt_cnt_o,
    output logic [CNT_WIDTH-1:0]  conflict_cnt_o
`endif
);

    logic [1:0]            w_req;
    logic [1:0]            w_gnt;
    logic                  w_any;
    logic                  w_aligned;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_ifRsp;
    logic                  w_ldRsp;

    logic                  r_rspValid;
    arb_port_e             r_rspPort;
    logic                  r_rspErr;

    // Requests are masked during reset so no grant or ROM access can escape.
    assign w_req = {ldBus.req, ifBus.req} & {2{~rst_i}};

    rr_arb2 #(
        .LAST_RESET(PORT_LD)
    ) u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_req    (w_req),
        .i_advance(w_any),
        .o_gnt    (w_gnt)
    );

    assign w_any     = |w_gnt;
    assign w_addr    = w_gnt[1] ? ldBus.addr : ifBus.addr;
    assign w_aligned = is_aligned(w_addr[1:0]);

    assign ifBus.gnt  = w_gnt[0];
    assign ldBus.gnt  = w_gnt[1];
    assign rom_ce_o   = w_any & w_aligned;
    assign rom_addr_o = rom_ce_o ? w_addr : '0;

    // Tag each grant with its owner so the next-cycle ROM data is steered back correctly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rspValid <= 1'b0;
            r_rspPort  <= PORT_IF;
            r_rspErr   <= 1'b0;
        end else begin
            r_rspValid <= w_any;
            if (w_any) begin
                r_rspPort <= w_gnt[1] ? PORT_LD : PORT_IF;
                r_rspErr  <= ~w_aligned;
            end
        end
    end

    assign w_ifRsp = r_rspValid && (r_rspPort == PORT_IF);
    assign w_ldRsp = r_rspValid && (r_rspPort == PORT_LD);

    assign ifBus.rvalid = w_ifRsp;
    assign ifBus.err    = w_ifRsp && r_rspErr;
    assign ifBus.rdata  = (w_ifRsp && !r_rspErr) ? rom_rdata_i : '0;

    assign ldBus.rvalid = w_ldRsp;
    assign ldBus.err    = w_ldRsp && r_rspErr;
    assign ldBus.rdata  = (w_ldRsp && !r_rspErr) ? rom_rdata_i : '0;

`ifdef ROM_ARB_PERF_EN
    logic [CNT_WIDTH-1:0] r_ifGntCnt;
    logic [CNT_WIDTH-1:0] r_ldGntCnt;
    logic [CNT_WIDTH-1:0] r_conflictCnt;

    // Saturating counters; a clear overrides any increment in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ifGntCnt    <= '0;
            r_ldGntCnt    <= '0;
            r_conflictCnt <= '0;
        end else if (perf_clr_i) begin
            r_ifGntCnt    <= '0;
            r_ldGntCnt    <= '0;
            r_conflictCnt <= '0;
        end else begin
            if (w_gnt[0] && (r_ifGntCnt != '1)) begin
                r_ifGntCnt <= r_ifGntCnt + CNT_WIDTH'(1);
            end
            if (w_gnt[1] && (r_ldGntCnt != '1)) begin
                r_ldGntCnt <= r_ldGntCnt + CNT_WIDTH'(1);
            end
            if ((&w_req) && (r_conflictCnt != '1)) begin
                r_conflictCnt <= r_conflictCnt + CNT_WIDTH'(1);
            end
        end
    end

    assign if_gnt_cnt_o   = r_ifGntCnt;
    assign ld_gnt_cnt_o   = r_ldGntCnt;
    assign conflict_cnt_o = r_conflictCnt;
`endif

endmodule
